// File: rtl/flit_forwarder.sv
// Read-side controller for one router input port: drains the port buffer,
// requests a route per packet and streams header, size and payload flits.
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif
`ifndef TAM_BUFFER
`define TAM_BUFFER 4
`endif

module flit_forwarder #(
    parameter int WIDTH = `TAM_FLIT,
    parameter int DEPTH = `TAM_BUFFER
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         head,
    input  logic [$clog2(DEPTH):0]   counter,
    output logic                     pull,
    output logic                     h,
    input  logic                     ack_h,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_av,
    input  logic                     data_ack,
    output logic                     sender,
    output logic                     eop
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROUTE,
        S_HDR,
        S_SIZE,
        S_PAYLOAD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] remaining;
    logic             nonempty;
    logic             size_zero;
    logic             last_payload;

    assign nonempty     = (counter != '0);
    assign size_zero    = (head == '0);
    assign last_payload = (remaining == WIDTH'(1));

    // Flits are presented straight from the buffer front: no output latency.
    assign data_out = head;
    assign data_av  = sender & nonempty;
    assign pull     = data_av & data_ack;
    assign eop      = pull & (((state == S_SIZE) & size_zero) |
                              ((state == S_PAYLOAD) & last_payload));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            h         <= 1'b0;
            sender    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (nonempty) begin
                        h     <= 1'b1;
                        state <= S_ROUTE;
                    end
                end
                S_ROUTE: begin
                    if (ack_h) begin
                        h      <= 1'b0;
                        sender <= 1'b1;
                        state  <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (pull)
                        state <= S_SIZE;
                end
                S_SIZE: begin
                    if (pull) begin
                        remaining <= head;
                        if (size_zero) begin
                            sender <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    // remaining only moves on an accepted flit, so underflow stalls hold it
                    if (pull) begin
                        remaining <= remaining - WIDTH'(1);
                        if (last_payload) begin
                            sender <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    h      <= 1'b0;
                    sender <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
